// File: rtl/aes_dec_pkg.sv
// Shared types and constants for the AES decoder round control.
// Block width, round-key index width, legal round counts and FSM states.
package aes_dec_pkg;

   localparam int AES_BLK_W = 128;
   localparam int RK_IDX_W  = 4;

   localparam int NR_128 = 10;
   localparam int NR_192 = 12;
   localparam int NR_256 = 14;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      DONE  = 2'd2
   } dec_fsm_e;

endpackage

// File: rtl/aes_dec_round_ctrl.sv
// Iterative AES inverse-cipher sequencer: owns the state register, drives the external
// inverse-round datapath one round per cycle and selects round keys from the key store.
module aes_dec_round_ctrl
   import aes_dec_pkg::*;
#(
   parameter int NR = 10
)
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 key_rdy,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [AES_BLK_W-1:0] in_data,
   output logic [RK_IDX_W-1:0]  rk_idx,
   input  logic [AES_BLK_W-1:0] rk_data,
   output logic [AES_BLK_W-1:0] rnd_in,
   output logic                 rnd_last,
   input  logic [AES_BLK_W-1:0] rnd_out,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [AES_BLK_W-1:0] out_data,
   output logic                 busy
);

   generate
      if (NR != NR_128 && NR != NR_192 && NR != NR_256) begin : g_bad_nr
         $error("aes_dec_round_ctrl: NR must be 10, 12 or 14");
      end
   endgenerate

   localparam logic [RK_IDX_W-1:0] LAST_KEY   = RK_IDX_W'(NR);
   localparam logic [RK_IDX_W-1:0] FIRST_RND  = RK_IDX_W'(NR - 1);

   dec_fsm_e               r_fsm;
   dec_fsm_e               w_fsm_next;
   logic [RK_IDX_W-1:0]    r_round;
   logic [RK_IDX_W-1:0]    w_round_next;
   logic [AES_BLK_W-1:0]   r_state;
   logic [AES_BLK_W-1:0]   w_state_next;
   logic                   r_out_valid;
   logic                   r_busy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fsm       <= IDLE;
         r_round     <= '0;
         r_state     <= '0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_fsm       <= w_fsm_next;
         r_round     <= w_round_next;
         r_state     <= w_state_next;
         r_out_valid <= (w_fsm_next == DONE);
         r_busy      <= (w_fsm_next == ROUND);
      end
   end

   always_comb begin
      w_fsm_next   = r_fsm;
      w_round_next = r_round;
      w_state_next = r_state;
      in_ready     = 1'b0;
      rk_idx       = LAST_KEY;
      rnd_last     = 1'b0;

      case (r_fsm)
         IDLE: begin
            in_ready = key_rdy;
            if (in_valid && key_rdy) begin
               w_state_next = in_data ^ rk_data;
               w_round_next = FIRST_RND;
               w_fsm_next   = ROUND;
            end
         end
         ROUND: begin
            rk_idx       = r_round;
            rnd_last     = (r_round == '0);
            w_state_next = rnd_out;
            if (r_round != '0) begin
               w_round_next = r_round - RK_IDX_W'(1);
            end else begin
               w_fsm_next = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               w_fsm_next = IDLE;
               in_ready   = key_rdy;
               // Chain the next block straight in so back-to-back traffic has no bubble.
               if (in_valid && key_rdy) begin
                  w_state_next = in_data ^ rk_data;
                  w_round_next = FIRST_RND;
                  w_fsm_next   = ROUND;
               end
            end
         end
         default: begin
            w_fsm_next = IDLE;
         end
      endcase
   end

   assign rnd_in    = r_state;
   assign out_data  = r_state;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;

endmodule

// File: doc/aes_dec_round_ctrl.md
# aes_dec_round_ctrl

Iterative round sequencer for the AES decoder. It owns the 128-bit state register, feeds it to the external combinational inverse-round datapath, and issues round-key indices to the key store. It applies the initial AddRoundKey, then NR inverse rounds, one per cycle. Upstream it takes ciphertext blocks; downstream it delivers plaintext, both over valid/ready handshakes.

## Interface
- NR, 10: number of rounds. Legal values are 10, 12 and 14 (AES-128/192/256); any other value is an elaboration error.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- key_rdy  in  1  key store holds a complete expanded schedule.
- in_valid  in  1  ciphertext block offered.
- in_ready  out  1  block accepted this cycle when in_valid & in_ready.
- in_data  in  128  ciphertext, byte 0 in [127:120].
- rk_idx  out  4  round-key index to the key store (asynchronous read).
- rk_data  in  128  round key rk_idx, valid in the same cycle.
- rnd_in  out  128  current state to the datapath (= state_q).
- rnd_last  out  1  final round: datapath skips InvMixColumns.
- rnd_out  in  128  datapath result: InvShiftRows, InvSubBytes, AddRoundKey(rk_data), then InvMixColumns unless rnd_last.
- out_valid  out  1  plaintext available.
- out_ready  in  1  consumer takes plaintext when out_valid & out_ready.
- out_data  out  128  plaintext (= state_q while out_valid).
- busy  out  1  high in ROUND state.

## Operation
- FSM states: IDLE, ROUND, DONE.
- IDLE
  - rk_idx = NR; in_ready = key_rdy.
  - On accept: state_q <= in_data ^ rk_data; round_q <= NR-1; go to ROUND.
- ROUND
  - rk_idx = round_q; rnd_last = (round_q == 0); state_q <= rnd_out.
  - If round_q != 0: round_q decrements.
  - If round_q == 0: go to DONE.
- DONE
  - out_valid = 1; rk_idx = NR; state_q is held.
  - On out_ready: go to IDLE.
  - If in_valid & key_rdy in the same cycle as out_ready, accept the new block directly. Load state_q as in IDLE and go to ROUND, so back-to-back blocks run with no bubble.
- in_ready = key_rdy & (IDLE | (DONE & out_ready)). It is never high in ROUND, so in_data is ignored there.
- round_q is 4 bits wide and never wraps below 0.
- key_rdy is sampled only at accept. If it drops during ROUND, the round still completes with whatever rk_data supplies. The key store owner must not rewrite the schedule while busy.
- Reset mid-operation: the block is abandoned. No out_valid is produced for it.

## Timing
- Reset values
  - State and counters: state = IDLE, round_q = 0, state_q = 0.
  - Outputs: out_valid = 0, busy = 0, rnd_last = 0, rk_idx = NR.
  - in_ready = key_rdy, since it is combinational.
- Latency: out_valid rises NR+1 rising edges after the accepting edge, counting the accept edge as edge 1.
  - NR = 10 gives 11 edges: 1 for the initial AddRoundKey plus 10 rounds.
- Throughput: one block per NR+1 cycles under continuous in_valid/out_ready.
- out_valid, busy and state_q are registered.
- in_ready, rk_idx and rnd_last are combinational from the FSM and round_q.
- out_data stays stable while out_valid & !out_ready.

## Structure
- Package aes_dec_pkg holds:
  - FSM state enum (IDLE/ROUND/DONE);
  - AES_BLK_W = 128;
  - RK_IDX_W = 4;
  - legal NR constants NR_128/NR_192/NR_256 = 10/12/14.
- No sub-module inside the block; the FSM and counter are inline.
- The inverse-round datapath (InvShiftRows byte permutation, InvSubBytes, InvMixColumns) and the key store stay external. The top-level decoder wires them to rnd_in/rnd_out and rk_idx/rk_data.

## Test plan
- FIPS-197 C.1 vector, with NR = 10, the real datapath and a key store loaded with key 000102030405060708090a0b0c0d0e0f:
  - in_data 69c4e0d86a7b0430d8cdb78070b4c55a gives out_data 00112233445566778899aabbccddeeff;
  - out_valid rises exactly 11 edges after accept.
- rk_idx sequence for that block: 10 at accept, then 9,8,…,0 in ROUND. rnd_last is high only in the rk_idx = 0 cycle.
- Back-to-back: two blocks with out_ready tied high.
  - Block 2 is accepted in block 1's DONE cycle.
  - Second out_valid follows 11 edges later.
  - Both plaintexts are correct.
- Backpressure: out_ready low for 5 cycles in DONE.
  - out_valid and out_data are held and in_ready stays low.
  - Block releases on the cycle out_ready rises.
- key_rdy = 0 with in_valid = 1 gives in_ready = 0, no accept, and busy stays 0. Raising key_rdy gives accept on that edge.
- Assert rst mid-ROUND (round_q = 5): outputs return to reset values immediately. No out_valid follows. A subsequent block decrypts correctly.
